ogfx_vram_arbiter: RTL

- Single-port Video-RAM arbiter for the graphic controller; shares one synchronous 16-bit RAM port between three requesters: display refresh fetch (read-only), CPU register interface (read/write) and GPU draw engine (read/write).
- Sits between the frame-fetch FIFO, CPU interface and GPU on one side and the Video-RAM macro on the other.
- Generates the per-requester "data ready during next cycle" strobes consumed by those blocks.

---
 rtl/ogfx_vram_arbiter_pkg.sv | 22 ++
 rtl/ogfx_vram_arbiter_if.sv | 52 +++++
 rtl/ogfx_vram_arb_rr.sv | 72 +++++++
 rtl/ogfx_vram_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/ogfx_vram_arbiter_pkg.sv
// Shared constants for the Video-RAM arbiter: widths, requester indices
// and the read-only write-enable code.
package ogfx_vram_arbiter_pkg;

  localparam int unsigned VRAM_MSB       = 16;
  localparam int unsigned VRAM_AW        = VRAM_MSB + 1;
  localparam int unsigned DW             = 16;
  localparam int unsigned WENW           = 2;
  localparam int unsigned NREQ           = 3;

  localparam int unsigned REQ_REF        = 0;
  localparam int unsigned REQ_CPU        = 1;
  localparam int unsigned REQ_GFX        = 2;

  localparam logic [WENW-1:0] WEN_READ   = 2'b11;

  localparam int unsigned STARVE_W       = 3;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef logic [NREQ-1:0] req_vec_t;

endpackage

// File: rtl/ogfx_vram_arbiter_if.sv
// Bundle of the three requester ports and the Video-RAM port.
// slave: arbiter view; master: requesters + RAM view.
interface ogfx_vram_arbiter_if
  import ogfx_vram_arbiter_pkg::*;
#(
  parameter int unsigned AW = VRAM_AW
) ();

  logic [AW-1:0]   ref_addr_i;
  logic            ref_cen_i;
  logic            ref_rdy_nxt_o;

  logic [AW-1:0]   cpu_addr_i;
  logic            cpu_cen_i;
  logic [WENW-1:0] cpu_wen_i;
  logic [DW-1:0]   cpu_din_i;
  logic            cpu_rdy_nxt_o;

  logic [AW-1:0]   gfx_addr_i;
  logic            gfx_cen_i;
  logic [WENW-1:0] gfx_wen_i;
  logic [DW-1:0]   gfx_din_i;
  logic            gfx_rdy_nxt_o;

  logic [AW-1:0]   vid_ram_addr_o;
  logic            vid_ram_cen_o;
  logic [WENW-1:0] vid_ram_wen_o;
  logic [DW-1:0]   vid_ram_din_o;
  logic [DW-1:0]   vid_ram_dout_i;
  logic [DW-1:0]   vid_ram_dout_o;

  modport slave (
    input  ref_addr_i, ref_cen_i,
    input  cpu_addr_i, cpu_cen_i, cpu_wen_i, cpu_din_i,
    input  gfx_addr_i, gfx_cen_i, gfx_wen_i, gfx_din_i,
    input  vid_ram_dout_i,
    output ref_rdy_nxt_o, cpu_rdy_nxt_o, gfx_rdy_nxt_o,
    output vid_ram_addr_o, vid_ram_cen_o, vid_ram_wen_o, vid_ram_din_o,
    output vid_ram_dout_o
  );

  modport master (
    output ref_addr_i, ref_cen_i,
    output cpu_addr_i, cpu_cen_i, cpu_wen_i, cpu_din_i,
    output gfx_addr_i, gfx_cen_i, gfx_wen_i, gfx_din_i,
    output vid_ram_dout_i,
    input  ref_rdy_nxt_o, cpu_rdy_nxt_o, gfx_rdy_nxt_o,
    input  vid_ram_addr_o, vid_ram_cen_o, vid_ram_wen_o, vid_ram_din_o,
    input  vid_ram_dout_o
  );

endinterface

// File: rtl/ogfx_vram_arb_rr.sv
// CPU/GPU round-robin pointer (0 = CPU favoured) and, when
// OGFX_VRAM_ARB_STARVE_EN is defined, a counter of consecutive refresh
// grants taken while CPU/GPU wait.
module ogfx_vram_arb_rr
  import ogfx_vram_arbiter_pkg::*;
`ifdef OGFX_VRAM_ARB_STARVE_EN
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic gnt_cpu_i,
  input  logic gnt_gfx_i,
`ifdef OGFX_VRAM_ARB_STARVE_EN
  input  logic gnt_ref_i,
  input  logic side_req_i,
  output logic starve_hit_c,
`endif
  output logic rr_o
);

  logic rr_q;
  logic rr_d;

  // Pointer toggles after every CPU or GPU grant.
  always_comb begin
    rr_d = rr_q;
    if (gnt_cpu_i || gnt_gfx_i) begin
      rr_d = ~rr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign rr_o = rr_q;

`ifdef OGFX_VRAM_ARB_STARVE_EN
  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;

  // Count refresh wins while the other side waits; saturating.
  always_comb begin
    starve_d = starve_q;
    if (gnt_cpu_i || gnt_gfx_i || !side_req_i) begin
      starve_d = '0;
    end else if (gnt_ref_i && (starve_q != {STARVE_W{1'b1}})) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign starve_hit_c = (starve_q == STARVE_W'(STARVE_MAX));
`endif

endmodule

// File: rtl/ogfx_vram_arbiter.sv
// Single-port Video-RAM arbiter: refresh > CPU/GPU round-robin, one grant
// per cycle, combinational grant with same-cycle rdy_nxt strobes.
// Optional macro OGFX_VRAM_ARB_STARVE_EN lets CPU/GPU pre-empt refresh
// after STARVE_MAX consecutive refresh grants.
module ogfx_vram_arbiter
  import ogfx_vram_arbiter_pkg::*;
#(
  parameter int unsigned AW = VRAM_AW
`ifdef OGFX_VRAM_ARB_STARVE_EN
  , parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
`endif
) (
  input  logic                 mclk,
  input  logic                 puc_rst,
  ogfx_vram_arbiter_if.slave   vbus
);

  logic            ref_req_c;
  logic            cpu_req_c;
  logic            gfx_req_c;
  logic            rr_sel;
  logic            starve_hit_c;
  req_vec_t        gnt_c;
  logic [AW-1:0]   addr_c;
  logic [WENW-1:0] wen_c;
  logic [DW-1:0]   din_c;

  assign ref_req_c = ~vbus.ref_cen_i;
  assign cpu_req_c = ~vbus.cpu_cen_i;
  assign gfx_req_c = ~vbus.gfx_cen_i;

  ogfx_vram_arb_rr
`ifdef OGFX_VRAM_ARB_STARVE_EN
    #(.STARVE_MAX (STARVE_MAX))
`endif
  u_rr (
    .clk          (mclk),
    .rst          (puc_rst),
    .gnt_cpu_i    (gnt_c[REQ_CPU]),
    .gnt_gfx_i    (gnt_c[REQ_GFX]),
`ifdef OGFX_VRAM_ARB_STARVE_EN
    .gnt_ref_i    (gnt_c[REQ_REF]),
    .side_req_i   (cpu_req_c | gfx_req_c),
    .starve_hit_c (starve_hit_c),
`endif
    .rr_o         (rr_sel)
  );

`ifndef OGFX_VRAM_ARB_STARVE_EN
  assign starve_hit_c = 1'b0;
`endif

  // Grant selection; a starved CPU/GPU only overrides refresh when one is waiting.
  always_comb begin
    gnt_c = '0;
    if (!puc_rst) begin
      if (ref_req_c && !(starve_hit_c && (cpu_req_c || gfx_req_c))) begin
        gnt_c[REQ_REF] = 1'b1;
      end else if (cpu_req_c && (!gfx_req_c || !rr_sel)) begin
        gnt_c[REQ_CPU] = 1'b1;
      end else if (gfx_req_c) begin
        gnt_c[REQ_GFX] = 1'b1;
      end
    end
  end

  // RAM port mux; idle port is a parked read with zero address/data.
  always_comb begin
    addr_c = '0;
    wen_c  = WEN_READ;
    din_c  = '0;
    if (gnt_c[REQ_REF]) begin
      addr_c = vbus.ref_addr_i;
    end else if (gnt_c[REQ_CPU]) begin
      addr_c = vbus.cpu_addr_i;
      wen_c  = vbus.cpu_wen_i;
      din_c  = vbus.cpu_din_i;
    end else if (gnt_c[REQ_GFX]) begin
      addr_c = vbus.gfx_addr_i;
      wen_c  = vbus.gfx_wen_i;
      din_c  = vbus.gfx_din_i;
    end
  end

  assign vbus.vid_ram_addr_o = addr_c;
  assign vbus.vid_ram_cen_o  = ~(|gnt_c);
  assign vbus.vid_ram_wen_o  = wen_c;
  assign vbus.vid_ram_din_o  = din_c;
  assign vbus.ref_rdy_nxt_o  = gnt_c[REQ_REF];
  assign vbus.cpu_rdy_nxt_o  = gnt_c[REQ_CPU];
  assign vbus.gfx_rdy_nxt_o  = gnt_c[REQ_GFX];
  assign vbus.vid_ram_dout_o = vbus.vid_ram_dout_i;

endmodule
